cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Collects completed results from the functional units (integer ALU, mul/div, branch, load/store) and drives them onto the common data bus (CDB). Each unit has a small per-source FIFO, and a round-robin arbiter grants up to `LANES` results per cycle to registered CDB lanes. The reservation stations, LSQ, dispatch stage and ROB all consume these lanes. This block is the producer end of the CDB broadcast protocol.

## Interface
- `NUM_SRC`, default 4: number of result sources. Index 0 = alu, 1 = mul, 2 = br, 3 = mem.
- `LANES`, default 2: number of CDB broadcast lanes.
- `FIFO_DEPTH`, default 2: entries per source FIFO. Must be a power of 2 and at least 2.
- `ROB_IDX_WIDTH`, default 5: ROB index width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush (mispredict). Synchronous.
- `src_valid` in [NUM_SRC]: source offers a result this cycle.
- `src_ready` out [NUM_SRC]: source FIFO can accept a result.
- `src_data` in [NUM_SRC][32]: result value.
- `src_rd_addr` in [NUM_SRC][5]: architectural destination register.
- `src_rob_idx` in [NUM_SRC][ROB_IDX_WIDTH]: ROB tag.
- `src_regf_we` in [NUM_SRC]: result writes the register file.
- `cdb_valid` out [LANES]: lane carries a broadcast this cycle.
- `cdb_data` out [LANES][32]: broadcast value.
- `cdb_rd_addr` out [LANES][5]: broadcast destination register.
- `cdb_rob_idx` out [LANES][ROB_IDX_WIDTH]: broadcast ROB tag.
- `cdb_regf_we` out [LANES]: broadcast write enable.
- `cdb_src` out [LANES][$clog2(NUM_SRC)]: source unit of each lane.

## Operation
- **Enqueue.** A result is accepted on an edge where `src_valid[i] && src_ready[i]`. It is pushed into FIFO i.
- **Ready.** `src_ready[i] = !full[i]`, computed combinationally from the occupancy count only. A full FIFO does not accept a push even in a cycle where it pops.
- **Arbitration.** Combinational over FIFO heads.
  - Scan sources starting at `rr_ptr`, ascending and wrapping modulo `NUM_SRC`.
  - The first non-empty source is granted lane 0, the next lane 1, and so on, up to `LANES` grants.
  - At most one pop per source per cycle.
- **Pop and broadcast.** Granted heads are popped on the edge. Their fields are registered into the `cdb_*` lanes on the same edge. Ungranted lanes register `cdb_valid = 0`; their payload is don't-care.
- **Pointer update.** `rr_ptr` advances to (last granted source + 1) mod `NUM_SRC`. If nothing is granted, `rr_ptr` holds.
- **Flush.** On an edge with `flush = 1`:
  - All FIFOs are emptied and `rr_ptr` is cleared to 0.
  - All `cdb_valid` lanes register 0.
  - Any handshake in that cycle is dropped.
  - The cycle after the flush edge shows an idle CDB and all `src_ready = 1`.
- **Reset.** `rst` behaves identically to flush and additionally clears all `cdb_*` payload registers to 0.
- **Reset values.** `cdb_valid = 0`, `cdb_data = 0`, `cdb_rd_addr = 0`, `cdb_rob_idx = 0`, `cdb_regf_we = 0`, `cdb_src = 0`, `src_ready = all 1`.
- **Priority.** `rst` takes priority over `flush`, and `flush` takes priority over all other activity.

## Timing
- **Latency.** A result accepted at edge k is visible on the CDB after edge k+1 at the earliest, i.e. 2 edges from handshake. There is no bypass path.
- **Throughput.** Each source can sustain 1 result/cycle only if it is granted every cycle. A source that is denied fills its FIFO and then sees `src_ready` fall.
- **Broadcast duration.** `cdb_*` outputs are held for exactly one cycle per broadcast. Consumers must capture them in that cycle.
- **Ordering.** Per-source FIFO order is preserved. No ordering is guaranteed across sources.
- **Pointer wrap.** FIFO read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The occupancy count is `$clog2(FIFO_DEPTH)+1` bits.
- **Full and empty.** A full FIFO with a pop in the same cycle becomes FIFO_DEPTH−1, and `src_ready` rises the next cycle. An empty FIFO with a push in the same cycle is not granted that cycle.

## Structure
- `cdb_lane_t` belongs in `rv32i_types`. It is a packed struct {valid, data, rd_addr, rob_idx, regf_we, src}.
- Also in `rv32i_types`: a source-index enum (alu/mul/br/mem = 0..3) and a `CDB_LANES` constant.
- One sub-module, `wb_fifo`: a parameterized synchronous FIFO with a push/pop/clear interface that exports `full`, `empty` and `head`. It is instantiated `NUM_SRC` times.
- The round-robin scan and the lane registers live in `cdb_arbiter` itself.

## Test plan
- **Single result.** After reset, alu pushes {data=0x1234, rd=5, rob=3} at edge 1. Then: `cdb_valid[0]=1` with those fields after edge 2, lane 1 invalid, idle after edge 3.
- **Four sources at once.** All four sources push once in the same cycle (`rr_ptr=0`). Then: lanes {alu, mul} broadcast on the first cycle and {br, mem} on the next; `rr_ptr` ends at 0.
- **Fairness and backpressure.** mem pushes every cycle while alu and mul also push every cycle. Then: mem is granted at least every 2nd cycle, `src_ready[3]` deasserts once FIFO 3 holds 2 entries, and no result is lost or duplicated (bench checks with a scoreboard by rob_idx).
- **Flush.** Flush while 3 FIFOs are non-empty and lanes are valid. Then: all `cdb_valid=0` after the flush edge, none of the pre-flush results are ever broadcast, and `src_ready` is all 1.
- **Reset mid-operation.** Assert `rst` with a full FIFO 1 and a simultaneous push. Then: all outputs equal their reset values, and the next push appears 2 edges later on lane 0.
- **Full FIFO, pop and push in the same cycle.** Full FIFO 2 is granted while `src_valid[2]=1`. Then: the push is not accepted that cycle (`src_ready[2]=0`), and it is accepted the following cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: source-unit encoding, default lane count and the lane record.
package rv32i_types;

    localparam int CDB_LANES = 2;
    localparam int CDB_ROB_W = 5;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MUL = 2'd1,
        SRC_BR  = 2'd2,
        SRC_MEM = 2'd3
    } src_idx_e;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          data;
        logic [4:0]           rd_addr;
        logic [CDB_ROB_W-1:0] rob_idx;
        logic                 regf_we;
        src_idx_e             src;
    } cdb_lane_t;

endpackage

// File: rtl/cdb_arbiter_wb.sv
// wb_fifo: small synchronous FIFO buffering one functional unit's results.
module wb_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count only: a pop never frees a slot for a same-cycle push.
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-unit result FIFOs, round-robin grant onto registered CDB lanes.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int LANES         = CDB_LANES,
    parameter int FIFO_DEPTH    = 2,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush,
    input  logic [NUM_SRC-1:0]                         src_valid,
    output logic [NUM_SRC-1:0]                         src_ready,
    input  logic [NUM_SRC-1:0][31:0]                   src_data,
    input  logic [NUM_SRC-1:0][4:0]                    src_rd_addr,
    input  logic [NUM_SRC-1:0][ROB_IDX_WIDTH-1:0]      src_rob_idx,
    input  logic [NUM_SRC-1:0]                         src_regf_we,
    output logic [LANES-1:0]                           cdb_valid,
    output logic [LANES-1:0][31:0]                     cdb_data,
    output logic [LANES-1:0][4:0]                      cdb_rd_addr,
    output logic [LANES-1:0][ROB_IDX_WIDTH-1:0]        cdb_rob_idx,
    output logic [LANES-1:0]                           cdb_regf_we,
    output logic [LANES-1:0][$clog2(NUM_SRC)-1:0]      cdb_src
);

    localparam int SRC_W   = $clog2(NUM_SRC);
    localparam int ENTRY_W = 32 + 5 + ROB_IDX_WIDTH + 1;

    logic [NUM_SRC-1:0]              fifo_full;
    logic [NUM_SRC-1:0]              fifo_empty;
    logic [NUM_SRC-1:0]              fifo_push;
    logic [NUM_SRC-1:0]              fifo_pop;
    logic [NUM_SRC-1:0][ENTRY_W-1:0] fifo_din;
    logic [NUM_SRC-1:0][ENTRY_W-1:0] fifo_head;

    logic [SRC_W-1:0]                rr_ptr;
    logic [SRC_W-1:0]                rr_ptr_nxt;
    logic [LANES-1:0]                lane_grant;
    logic [LANES-1:0][SRC_W-1:0]     lane_sel;
    logic [LANES-1:0][ENTRY_W-1:0]   lane_head;

    assign src_ready = ~fifo_full;
    assign fifo_push = src_valid & ~fifo_full;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign fifo_din[s] = {src_data[s], src_rd_addr[s], src_rob_idx[s], src_regf_we[s]};

        wb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clear (flush),
            .push  (fifo_push[s]),
            .pop   (fifo_pop[s]),
            .din   (fifo_din[s]),
            .full  (fifo_full[s]),
            .empty (fifo_empty[s]),
            .head  (fifo_head[s])
        );
    end

    // Scan from rr_ptr with wraparound; constant-index compares keep every select static.
    always_comb begin : arb
        int                 n_grant;
        int                 idx;
        logic               hit;
        logic [ENTRY_W-1:0] sel_head;

        fifo_pop   = '0;
        lane_grant = '0;
        lane_sel   = '0;
        lane_head  = '0;
        rr_ptr_nxt = rr_ptr;
        n_grant    = 0;
        idx        = 0;
        hit        = 1'b0;
        sel_head   = '0;

        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end

            hit      = 1'b0;
            sel_head = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (s == idx) begin
                    hit      = !fifo_empty[s];
                    sel_head = fifo_head[s];
                end
            end

            if (hit && (n_grant < LANES)) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (s == idx) begin
                        fifo_pop[s] = 1'b1;
                    end
                end
                for (int l = 0; l < LANES; l++) begin
                    if (l == n_grant) begin
                        lane_grant[l] = 1'b1;
                        lane_sel[l]   = SRC_W'(idx);
                        lane_head[l]  = sel_head;
                    end
                end
                rr_ptr_nxt = (idx + 1 == NUM_SRC) ? '0 : SRC_W'(idx + 1);
                n_grant    = n_grant + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cdb_valid   <= '0;
            cdb_data    <= '0;
            cdb_rd_addr <= '0;
            cdb_rob_idx <= '0;
            cdb_regf_we <= '0;
            cdb_src     <= '0;
        end else if (flush) begin
            rr_ptr    <= '0;
            cdb_valid <= '0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            cdb_valid <= lane_grant;
            // Idle lanes keep stale payload; consumers qualify everything with cdb_valid.
            for (int l = 0; l < LANES; l++) begin
                if (lane_grant[l]) begin
                    cdb_data[l]    <= lane_head[l][ENTRY_W-1 -: 32];
                    cdb_rd_addr[l] <= lane_head[l][ROB_IDX_WIDTH+5 -: 5];
                    cdb_rob_idx[l] <= lane_head[l][ROB_IDX_WIDTH:1];
                    cdb_regf_we[l] <= lane_head[l][0];
                    cdb_src[l]     <= lane_sel[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int NS    = 4;
    localparam int NL    = 2;
    localparam int DEPTH = 2;
    localparam int RW    = 5;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic [NS-1:0]           src_valid = '0;
    logic [NS-1:0]           src_ready;
    logic [NS-1:0][31:0]     src_data = '0;
    logic [NS-1:0][4:0]      src_rd_addr = '0;
    logic [NS-1:0][RW-1:0]   src_rob_idx = '0;
    logic [NS-1:0]           src_regf_we = '0;
    logic [NL-1:0]           cdb_valid;
    logic [NL-1:0][31:0]     cdb_data;
    logic [NL-1:0][4:0]      cdb_rd_addr;
    logic [NL-1:0][RW-1:0]   cdb_rob_idx;
    logic [NL-1:0]           cdb_regf_we;
    logic [NL-1:0][1:0]      cdb_src;

    cdb_arbiter #(
        .NUM_SRC       (NS),
        .LANES         (NL),
        .FIFO_DEPTH    (DEPTH),
        .ROB_IDX_WIDTH (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_data    (src_data),
        .src_rd_addr (src_rd_addr),
        .src_rob_idx (src_rob_idx),
        .src_regf_we (src_regf_we),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .cdb_rd_addr (cdb_rd_addr),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_regf_we (cdb_regf_we),
        .cdb_src     (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   data;
        logic [4:0]    rd;
        logic [RW-1:0] rob;
        logic          we;
    } res_t;

    typedef struct {
        int            cyc;
        int            lane;
        int            src;
        logic [31:0]   data;
        logic [4:0]    rd;
        logic [RW-1:0] rob;
        logic          we;
    } exp_t;

    res_t  mq [NS][$];
    exp_t  exp_q [$];
    int    m_rr = 0;
    int    edge_cnt = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [RW-1:0] rob_ctr = '0;
    exp_t  mon_e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the model predicts what the coming edge does.
    task automatic drive_cycle(input logic [NS-1:0] v, input logic fl, input logic rs, input logic fixed);
        logic [NS-1:0] exp_rdy;
        int            n;
        int            s;
        int            last;
        res_t          r;
        exp_t          e;
        @(posedge clk);
        #2;
        for (int i = 0; i < NS; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
        check("src_ready", 64'(src_ready), 64'(exp_rdy));

        src_valid = v;
        flush     = fl;
        rst       = rs;
        for (int i = 0; i < NS; i++) begin
            src_data[i]    = $urandom;
            src_rd_addr[i] = 5'($urandom_range(0, 31));
            src_regf_we[i] = 1'($urandom_range(0, 1));
            src_rob_idx[i] = rob_ctr;
            rob_ctr        = rob_ctr + 1'b1;
        end
        if (fixed) begin
            src_data[0]    = 32'h1234;
            src_rd_addr[0] = 5'd5;
            src_rob_idx[0] = 5'd3;
            src_regf_we[0] = 1'b1;
        end

        if (rs || fl) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = 0;
        end else begin
            n    = 0;
            last = -1;
            for (int k = 0; k < NS; k++) begin
                s = (m_rr + k) % NS;
                if (mq[s].size() > 0 && n < NL) begin
                    r      = mq[s].pop_front();
                    e.cyc  = edge_cnt + 1;
                    e.lane = n;
                    e.src  = s;
                    e.data = r.data;
                    e.rd   = r.rd;
                    e.rob  = r.rob;
                    e.we   = r.we;
                    exp_q.push_back(e);
                    last = s;
                    n++;
                end
            end
            if (last >= 0) m_rr = (last + 1) % NS;
            for (int i = 0; i < NS; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    r.data = src_data[i];
                    r.rd   = src_rd_addr[i];
                    r.rob  = src_rob_idx[i];
                    r.we   = src_regf_we[i];
                    mq[i].push_back(r);
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cdb_valid"},   64'(cdb_valid),   64'(0));
        check({tag, "_cdb_data"},    64'(cdb_data),    64'(0));
        check({tag, "_cdb_rd_addr"}, 64'(cdb_rd_addr), 64'(0));
        check({tag, "_cdb_rob_idx"}, 64'(cdb_rob_idx), 64'(0));
        check({tag, "_cdb_regf_we"}, 64'(cdb_regf_we), 64'(0));
        check({tag, "_cdb_src"},     64'(cdb_src),     64'(0));
        check({tag, "_src_ready"},   64'(src_ready),   64'hF);
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (cdb_valid[l] === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL cdb_unexpected lane %0d edge %0d: got src %0d rob %0d, expected no broadcast",
                             l, edge_cnt, cdb_src[l], cdb_rob_idx[l]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != edge_cnt || mon_e.lane != l || mon_e.src != int'(cdb_src[l]) ||
                        mon_e.data !== cdb_data[l] || mon_e.rd !== cdb_rd_addr[l] ||
                        mon_e.rob !== cdb_rob_idx[l] || mon_e.we !== cdb_regf_we[l]) begin
                        n_bad++;
                        $display("FAIL cdb_lane edge %0d lane %0d: got src %0d data %h rd %0d rob %0d we %0b, expected edge %0d lane %0d src %0d data %h rd %0d rob %0d we %0b",
                                 edge_cnt, l, cdb_src[l], cdb_data[l], cdb_rd_addr[l], cdb_rob_idx[l], cdb_regf_we[l],
                                 mon_e.cyc, mon_e.lane, mon_e.src, mon_e.data, mon_e.rd, mon_e.rob, mon_e.we);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            n_bad++;
            $display("FAIL cdb_missing edge %0d: got no broadcast, expected src %0d rob %0d on lane %0d",
                     edge_cnt, exp_q[0].src, exp_q[0].rob, exp_q[0].lane);
            while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        drive_cycle('0, 1'b0, 1'b1, 1'b0);
        drive_cycle('0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_reset_vals("reset");

        // single alu result
        drive_cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        repeat (3) drive_cycle('0, 1'b0, 1'b0, 1'b0);

        // all four sources at once
        drive_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (3) drive_cycle('0, 1'b0, 1'b0, 1'b0);

        // fairness and backpressure: alu, mul, mem every cycle
        repeat (16) drive_cycle(4'b1011, 1'b0, 1'b0, 1'b0);
        repeat (4) drive_cycle('0, 1'b0, 1'b0, 1'b0);

        // flush with busy FIFOs and live lanes
        repeat (3) drive_cycle(4'b0111, 1'b0, 1'b0, 1'b0);
        drive_cycle('0, 1'b1, 1'b0, 1'b0);
        drive_cycle('0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_cdb_valid", 64'(cdb_valid), 64'(0));
        check("flush_src_ready", 64'(src_ready), 64'hF);
        repeat (3) drive_cycle('0, 1'b0, 1'b0, 1'b0);

        // reset with full FIFOs and a simultaneous push
        repeat (4) drive_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        check("fifo1_full_ready", 64'(src_ready[1]), 64'(0));
        drive_cycle(4'b0010, 1'b0, 1'b1, 1'b0);
        drive_cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_reset_vals("midreset");
        repeat (3) drive_cycle('0, 1'b0, 1'b0, 1'b0);

        // saturated traffic: full FIFOs granted while still offering
        repeat (8) drive_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (4) drive_cycle('0, 1'b0, 1'b0, 1'b0);

        // random traffic with occasional flush and reset
        repeat (400) begin
            drive_cycle(4'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0), 1'b0);
        end
        repeat (6) drive_cycle('0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
